// File: rtl/arb_resp_router_if.sv
// ============================================================================
// Module  : arb_resp_router_if
// Brief   : Issue/response bundle between the arbitrated bus and its router.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface arb_resp_router_if #(
   parameter int PORTS  = 4,
   parameter int DEPTH  = 8,
   parameter int DATA_W = 32
);
   localparam int IW = $clog2(PORTS);
   localparam int CW = $clog2(DEPTH) + 1;

   logic              issue_valid;
   logic [IW-1:0]     issue_port;
   logic              issue_ready;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_ready;
   logic [PORTS-1:0]  port_rsp_valid;
   logic [DATA_W-1:0] port_rsp_data;
   logic [PORTS-1:0]  port_rsp_ready;
   logic [CW-1:0]     outstanding;
   logic              err_unexpected;

   // Router side
   modport slave (
      input  issue_valid, issue_port, rsp_valid, rsp_data, port_rsp_ready,
      output issue_ready, rsp_ready, port_rsp_valid, port_rsp_data,
             outstanding, err_unexpected
   );

   // Environment side (arbiter, downstream target, port masters)
   modport master (
      output issue_valid, issue_port, rsp_valid, rsp_data, port_rsp_ready,
      input  issue_ready, rsp_ready, port_rsp_valid, port_rsp_data,
             outstanding, err_unexpected
   );
endinterface

`default_nettype wire

// File: rtl/arb_resp_router.sv
// ============================================================================
// Module  : arb_resp_router
// Brief   : Routes in-order downstream responses back to the issuing port.
//           Macro ARB_RESP_ROUTER_REG_OUT_EN adds a registered output stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_resp_router #(
   parameter int PORTS  = 4,
   parameter int DEPTH  = 8,
   parameter int DATA_W = 32
) (
   input wire               clk,
   input wire               rst_n,
   arb_resp_router_if.slave bus
);
   localparam int IW = $clog2(PORTS);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0]    C_FULL = CW'(DEPTH);
   localparam logic [PORTS-1:0] C_ONE  = PORTS'(1);

   logic [IW-1:0] r_fifo [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_err;

   logic          w_empty;
   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic          w_ready;
   logic [IW-1:0] w_head;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == C_FULL);
   assign w_head  = r_fifo[r_rd_ptr];
   assign w_push  = bus.issue_valid && !w_full;
   assign w_pop   = bus.rsp_valid && w_ready && !w_empty;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= bus.issue_port;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         // A response with nothing recorded is swallowed and flagged.
         if (bus.rsp_valid && w_empty) r_err <= 1'b1;
      end
   end

`ifdef ARB_RESP_ROUTER_REG_OUT_EN
   logic              r_out_valid;
   logic [IW-1:0]     r_out_idx;
   logic [DATA_W-1:0] r_out_data;
   logic [PORTS-1:0]  w_out_oh;
   logic              w_out_take;

   assign w_out_oh   = C_ONE << r_out_idx;
   assign w_out_take = r_out_valid && |(bus.port_rsp_ready & w_out_oh);
   assign w_ready    = w_empty || !r_out_valid || w_out_take;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_idx   <= '0;
         r_out_data  <= '0;
      end else if (w_pop) begin
         r_out_valid <= 1'b1;
         r_out_idx   <= w_head;
         r_out_data  <= bus.rsp_data;
      end else if (w_out_take) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.port_rsp_valid = r_out_valid ? w_out_oh : '0;
   assign bus.port_rsp_data  = r_out_data;
`else
   logic [PORTS-1:0] w_head_oh;

   assign w_head_oh = C_ONE << w_head;
   assign w_ready   = w_empty || |(bus.port_rsp_ready & w_head_oh);

   assign bus.port_rsp_valid = (bus.rsp_valid && !w_empty) ? w_head_oh : '0;
   assign bus.port_rsp_data  = bus.rsp_data;
`endif

   assign bus.issue_ready    = !w_full;
   assign bus.rsp_ready      = w_ready;
   assign bus.outstanding    = r_count;
   assign bus.err_unexpected = r_err;
endmodule

`default_nettype wire

// File: tb/tb_arb_resp_router.sv
// ============================================================================
// Module  : tb_arb_resp_router
// Brief   : Directed and random checks of arb_resp_router (pass-through build)
//           against a queue-based model of the issue order.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arb_resp_router;
   localparam int PORTS  = 4;
   localparam int DEPTH  = 8;
   localparam int DATA_W = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   arb_resp_router_if #(.PORTS(PORTS), .DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

   arb_resp_router #(.PORTS(PORTS), .DEPTH(DEPTH), .DATA_W(DATA_W)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];      // port indices in issue order
   bit m_err  = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
      n_checks++;
      assert (obs === req) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
      end
   endtask

   // One clock: compare all outputs mid-cycle, then advance the model at the edge.
   task automatic tick();
      int               sz;
      logic [PORTS-1:0] ev;
      @(negedge clk);
      sz = exp_q.size();
      chk("outstanding", bus.outstanding, sz);
      chk("issue_ready", bus.issue_ready, (sz != DEPTH));
      chk("err_unexpected", bus.err_unexpected, m_err);
      ev = '0;
      if (bus.rsp_valid && sz != 0) ev[exp_q[0]] = 1'b1;
      chk("port_rsp_valid", bus.port_rsp_valid, ev);
      if (bus.rsp_valid) begin
         if (sz == 0) chk("rsp_ready_unexp", bus.rsp_ready, 1'b1);
         else begin
            chk("rsp_ready", bus.rsp_ready, bus.port_rsp_ready[exp_q[0]]);
            chk("port_rsp_data", bus.port_rsp_data, bus.rsp_data);
         end
      end
      @(posedge clk);
      if (bus.rsp_valid) begin
         if (sz == 0) m_err = 1'b1;
         else if (bus.port_rsp_ready[exp_q[0]]) void'(exp_q.pop_front());
      end
      if (bus.issue_valid && sz != DEPTH) exp_q.push_back(int'(bus.issue_port));
      #1;
   endtask

   task automatic issue(input int port);
      bus.issue_valid = 1'b1;
      bus.issue_port  = port[1:0];
      tick();
      bus.issue_valid = 1'b0;
   endtask

   task automatic drain();
      bus.issue_valid    = 1'b0;
      bus.rsp_valid      = 1'b1;
      bus.port_rsp_ready = '1;
      for (int k = 0; k < DEPTH + 2 && exp_q.size() != 0; k++) begin
         bus.rsp_data = $urandom;
         tick();
      end
      bus.rsp_valid = 1'b0;
      chk("drained", exp_q.size(), 0);
   endtask

   logic [PORTS-1:0] seq_oh [3];

   initial begin
      seq_oh[0] = 4'b0100;
      seq_oh[1] = 4'b0001;
      seq_oh[2] = 4'b1000;
      bus.issue_valid    = 1'b0;
      bus.issue_port     = '0;
      bus.rsp_valid      = 1'b0;
      bus.rsp_data       = '0;
      bus.port_rsp_ready = '0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_outstanding", bus.outstanding, 0);
      chk("rst_err", bus.err_unexpected, 0);
      chk("rst_port_valid", bus.port_rsp_valid, 0);
      chk("rst_issue_ready", bus.issue_ready, 1);
      rst_n = 1'b1;
      tick();

      // Ports 2,0,3 then three in-order responses
      issue(2); issue(0); issue(3);
      chk("seq_outstanding", bus.outstanding, 3);
      for (int i = 0; i < 3; i++) begin
         bus.rsp_valid      = 1'b1;
         bus.rsp_data       = 32'hD000_0000 + i;
         bus.port_rsp_ready = '1;
         #1;
         chk("seq_onehot", bus.port_rsp_valid, seq_oh[i]);
         tick();
      end
      bus.rsp_valid = 1'b0;
      tick();

      // Fill to DEPTH, overflow attempt ignored, one pop reopens issue
      for (int i = 0; i < DEPTH; i++) issue($urandom_range(0, PORTS - 1));
      chk("full_outstanding", bus.outstanding, DEPTH);
      chk("full_issue_ready", bus.issue_ready, 0);
      issue($urandom_range(0, PORTS - 1));
      chk("ovf_outstanding", bus.outstanding, DEPTH);
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = $urandom;
      tick();
      bus.rsp_valid = 1'b0;
      chk("reopen_issue_ready", bus.issue_ready, 1);

      // Refill, then simultaneous issue and response across pointer wrap
      issue($urandom_range(0, PORTS - 1));
      for (int i = 0; i < 16; i++) begin
         bus.issue_valid = 1'b1;
         bus.issue_port  = 2'($urandom_range(0, PORTS - 1));
         bus.rsp_valid   = 1'b1;
         bus.rsp_data    = $urandom;
         tick();
      end
      drain();

      // Head port 1 stalls; other ports ready must not matter
      issue(1); issue(2);
      bus.rsp_valid      = 1'b1;
      bus.rsp_data       = 32'hCAFE_0001;
      bus.port_rsp_ready = 4'b1101;
      #1;
      chk("stall_rsp_ready", bus.rsp_ready, 0);
      repeat (5) tick();
      chk("stall_outstanding", bus.outstanding, 2);
      drain();

      // Unexpected response, sticky error
      bus.rsp_valid      = 1'b1;
      bus.rsp_data       = 32'hBAD0_0000;
      bus.port_rsp_ready = '0;
      #1;
      chk("unexp_rsp_ready", bus.rsp_ready, 1);
      chk("unexp_port_valid", bus.port_rsp_valid, 0);
      tick();
      bus.rsp_valid = 1'b0;
      repeat (3) tick();
      chk("unexp_sticky", bus.err_unexpected, 1);

      // Asynchronous reset with 3 outstanding
      issue(0); issue(1); issue(3);
      rst_n = 1'b0;
      #2;
      chk("midrst_outstanding", bus.outstanding, 0);
      chk("midrst_err", bus.err_unexpected, 0);
      exp_q.delete();
      m_err = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = $urandom;
      tick();
      bus.rsp_valid = 1'b0;
      tick();

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         bus.issue_valid    = ($urandom_range(0, 99) < 60);
         bus.issue_port     = 2'($urandom_range(0, PORTS - 1));
         bus.rsp_valid      = ($urandom_range(0, 99) < 50);
         bus.rsp_data       = $urandom;
         bus.port_rsp_ready = 4'($urandom) | 4'($urandom);
         tick();
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
